clock_glitch_monitor: RTL and testbench

Single-clock monitor for the output of the glitchless clock mux: a free-running reference clock samples the muxed clock (`mon_clk`) through a synchronizer and measures every high phase, low phase and period in reference cycles. Phases shorter than programmable minimums are flagged as glitches and counted. The block sits beside `glitchless_mux_2to1` in silicon and in benches, and closes the loop on clock switching by reading what the mux produces.

---
 rtl/clock_glitch_monitor_pkg.sv | 22 ++
 rtl/bit_synchronizer.sv | 23 ++
 rtl/clock_glitch_monitor.sv | 167 ++++++++++++++++
 tb/tb_clock_glitch_monitor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_glitch_monitor_pkg.sv
// Shared types, default widths and helpers for the clock glitch monitor.
package clock_glitch_monitor_pkg;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_GCNT_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STUCK_LIMIT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } mon_state_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/clock_glitch_monitor.sv
// Measures high/low phases and period of mon_clk in clk cycles and flags short phases.
// Optional stuck-clock detection is enabled with the CLK_MON_STUCK_DET_EN macro.
module clock_glitch_monitor
  import clock_glitch_monitor_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GCNT_W      = DEF_GCNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mon_clk,
  input  logic [CNT_W-1:0]  min_high,
  input  logic [CNT_W-1:0]  min_low,
  input  logic              clr,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  low_cnt,
  output logic [CNT_W:0]    period_cnt,
  output logic              meas_valid,
  output logic              glitch,
  output logic              glitch_sticky,
  output logic [GCNT_W-1:0] glitch_cnt,
  output logic              stuck
);

  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic [CNT_W-1:0] run_cnt_reg;
  mon_state_e       state_reg;
  mon_state_e       state_next;
  logic             take_high;
  logic             take_low;
  logic             glitch_next;
  logic             high_done_reg;

  bit_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (mon_clk),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign any_edge = rise | fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt_reg <= '0;
    end else if (any_edge) begin
      run_cnt_reg <= CNT_W'(1);
    end else begin
      run_cnt_reg <= CNT_W'(sat_inc(32'(run_cnt_reg), CNT_W));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The first edge after IDLE only establishes phase; measurements start on the next one.
  always_comb begin
    state_next = state_reg;
    take_high  = 1'b0;
    take_low   = 1'b0;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_next = HIGH;
          end else if (fall) begin
            state_next = LOW;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
            take_high  = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state_next = HIGH;
            take_low   = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign glitch_next = (take_high && (run_cnt_reg < min_high)) ||
                       (take_low  && (run_cnt_reg < min_low));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      high_cnt      <= '0;
      low_cnt       <= '0;
      period_cnt    <= '0;
      meas_valid    <= 1'b0;
      glitch        <= 1'b0;
      glitch_sticky <= 1'b0;
      glitch_cnt    <= '0;
      high_done_reg <= 1'b0;
    end else begin
      meas_valid <= take_low && high_done_reg;
      glitch     <= glitch_next;
      if (take_high) begin
        high_cnt      <= run_cnt_reg;
        high_done_reg <= 1'b1;
      end
      if (take_low) begin
        low_cnt    <= run_cnt_reg;
        period_cnt <= {1'b0, high_cnt} + {1'b0, run_cnt_reg};
      end
      if (clr) begin
        high_done_reg <= 1'b0;
        glitch_sticky <= 1'b0;
        glitch_cnt    <= '0;
      end else if (glitch_next) begin
        glitch_sticky <= 1'b1;
        glitch_cnt    <= GCNT_W'(sat_inc(32'(glitch_cnt), GCNT_W));
      end
    end
  end

`ifdef CLK_MON_STUCK_DET_EN
  logic stuck_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stuck_reg <= 1'b0;
    end else if (clr || any_edge) begin
      stuck_reg <= 1'b0;
    end else if (32'(run_cnt_reg) >= 32'(STUCK_LIMIT)) begin
      stuck_reg <= 1'b1;
    end
  end

  assign stuck = stuck_reg;
`else
  logic unused_stuck_limit;
  assign unused_stuck_limit = ^STUCK_LIMIT;
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_clock_glitch_monitor.sv
// Scoreboard bench for clock_glitch_monitor: random phase streams, clears and resets are
// scored against a phase-level model; honours CLK_MON_STUCK_DET_EN for the stuck output.
module tb_clock_glitch_monitor;

  localparam int CNT_W       = 8;
  localparam int GCNT_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int STUCK_LIMIT = 255;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int GCNT_MAX    = (1 << GCNT_W) - 1;
`ifdef CLK_MON_STUCK_DET_EN
  localparam int STUCK_EXP = 1;
`else
  localparam int STUCK_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              mon_clk;
  logic [CNT_W-1:0]  min_high;
  logic [CNT_W-1:0]  min_low;
  logic              clr;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  low_cnt;
  logic [CNT_W:0]    period_cnt;
  logic              meas_valid;
  logic              glitch;
  logic              glitch_sticky;
  logic [GCNT_W-1:0] glitch_cnt;
  logic              stuck;

  clock_glitch_monitor #(
    .CNT_W      (CNT_W),
    .GCNT_W     (GCNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .mon_clk      (mon_clk),
    .min_high     (min_high),
    .min_low      (min_low),
    .clr          (clr),
    .high_cnt     (high_cnt),
    .low_cnt      (low_cnt),
    .period_cnt   (period_cnt),
    .meas_valid   (meas_valid),
    .glitch       (glitch),
    .glitch_sticky(glitch_sticky),
    .glitch_cnt   (glitch_cnt),
    .stuck        (stuck)
  );

  always #5 clk = ~clk;

  typedef struct { int high; int low; } meas_t;
  typedef struct { bit is_high; int len; int cnt; } glitch_t;

  meas_t   meas_q[$];
  glitch_t glitch_q[$];
  int checks = 0;
  int errors = 0;

  // Phase-level model of what the monitor should report
  int mh, ml;
  int pend_mh, pend_ml;
  bit mins_pending = 1'b0;
  bit cur_level = 1'b0;
  int cur_len = 0;
  bit cur_start_seen = 1'b0;
  bit cur_clr = 1'b0;
  bit prev_high_meas = 1'b0;
  int last_high = 0;
  int gcnt_m = 0;
  bit sticky_m = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic push_glitch(input bit is_high, input int len);
    gcnt_m   = (gcnt_m >= GCNT_MAX) ? GCNT_MAX : gcnt_m + 1;
    sticky_m = 1'b1;
    glitch_q.push_back('{is_high: is_high, len: len, cnt: gcnt_m});
  endtask

  // A phase is measured only if the monitor saw both bounding edges with no clear in between.
  task automatic end_phase(input bit masked);
    bit measured;
    int ls;
    measured = cur_start_seen && !cur_clr && !masked;
    ls = sat(cur_len);
    if (measured) begin
      if (cur_level) begin
        last_high = ls;
        if (mh != 0 && ls < mh) push_glitch(1'b1, ls);
      end else begin
        if (prev_high_meas) meas_q.push_back('{high: last_high, low: ls});
        if (ml != 0 && ls < ml) push_glitch(1'b0, ls);
      end
    end
    prev_high_meas = measured && cur_level;
    if (masked) begin
      gcnt_m   = 0;
      sticky_m = 1'b0;
    end
    cur_start_seen = !masked;
    cur_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_cnt"}, int'(high_cnt), 0);
    check({tag, "_low_cnt"}, int'(low_cnt), 0);
    check({tag, "_period_cnt"}, int'(period_cnt), 0);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_glitch"}, int'(glitch), 0);
    check({tag, "_glitch_sticky"}, int'(glitch_sticky), 0);
    check({tag, "_glitch_cnt"}, int'(glitch_cnt), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
  endtask

  // mode: 0 plain, 1 clr mid-phase, 2 clr over the starting edge, 3 reset mid-phase
  task automatic drive_phase(input int len, input int mode);
    end_phase(mode == 2);
    mon_clk   = ~mon_clk;
    cur_level = mon_clk;
    cur_len   = len;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (mode == 2 && c == 1) clr = 1'b1;
      if (mode == 2 && c == 6) clr = 1'b0;
      if (mode == 2 && c == 7) begin
        check("clr_collision_glitch_cnt", int'(glitch_cnt), 0);
        check("clr_collision_sticky", int'(glitch_sticky), 0);
      end
      if (mode == 1 && c == 5) begin
        clr      = 1'b1;
        cur_clr  = 1'b1;
        gcnt_m   = 0;
        sticky_m = 1'b0;
      end
      if (mode == 1 && c == 6) clr = 1'b0;
      if (mode == 1 && c == 7) check("clr_mid_glitch_cnt", int'(glitch_cnt), 0);
      if (c == 5 && len >= 8) check("stuck_after_edge", int'(stuck), 0);
      if (c == 5 && mins_pending) begin
        min_high = CNT_W'(pend_mh);
        min_low  = CNT_W'(pend_ml);
        mh = pend_mh;
        ml = pend_ml;
        mins_pending = 1'b0;
      end
      if (len >= 300 && c == 290) check("stuck_long_phase", int'(stuck), STUCK_EXP);
      if (mode == 3 && c == 8) begin
        check("pending_meas_at_reset", meas_q.size(), 0);
        check("pending_glitch_at_reset", glitch_q.size(), 0);
        rstn = 1'b0;
      end
      if (mode == 3 && c == 9) begin
        mon_clk        = 1'b0;
        cur_level      = 1'b0;
        cur_start_seen = 1'b0;
        cur_clr        = 1'b0;
        prev_high_meas = 1'b0;
        last_high      = 0;
        gcnt_m         = 0;
        sticky_m       = 1'b0;
        meas_q.delete();
        glitch_q.delete();
      end
      if (mode == 3 && c == 11) begin
        check_all_zero("mid_reset");
        rstn = 1'b1;
      end
    end
  endtask

  task automatic set_mins(input int a, input int b);
    pend_mh = a;
    pend_ml = b;
    mins_pending = 1'b1;
    drive_phase(12, 0);
  endtask

  task automatic random_segment(input int n);
    int len;
    int mode;
    set_mins($urandom_range(0, 5), $urandom_range(0, 5));
    for (int i = 0; i < n; i++) begin
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
      mode = (len >= 8 && $urandom_range(0, 7) == 0) ? 1 : 0;
      drive_phase(len, mode);
    end
  endtask

  // Monitor: every reported event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    meas_t   m;
    glitch_t g;
    if (rstn) begin
      if (meas_valid) begin
        if (meas_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_meas_valid high=%0d low=%0d at %0t", high_cnt, low_cnt, $time);
        end else begin
          m = meas_q.pop_front();
          check("meas_high_cnt", int'(high_cnt), m.high);
          check("meas_low_cnt", int'(low_cnt), m.low);
          check("meas_period_cnt", int'(period_cnt), m.high + m.low);
        end
      end
      if (glitch) begin
        if (glitch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_glitch high=%0d low=%0d at %0t", high_cnt, low_cnt, $time);
        end else begin
          g = glitch_q.pop_front();
          if (g.is_high) check("glitch_high_cnt", int'(high_cnt), g.len);
          else check("glitch_low_cnt", int'(low_cnt), g.len);
          check("glitch_cnt", int'(glitch_cnt), g.cnt);
          check("glitch_sticky", int'(glitch_sticky), 1);
        end
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    mon_clk  = 1'b0;
    clr      = 1'b0;
    min_high = CNT_W'(2);
    min_low  = CNT_W'(2);
    mh = 2;
    ml = 2;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Steady 8-cycle clock at 50% duty
    repeat (8) drive_phase(4, 0);

    // Single 2-cycle high pulse against min_high = 3
    set_mins(3, 2);
    if (cur_level) drive_phase(4, 0);
    drive_phase(2, 0);
    repeat (4) drive_phase(4, 0);

    repeat (3) random_segment(40);

    // Counter saturation on a 300-cycle high phase
    if (cur_level) drive_phase(6, 0);
    drive_phase(300, 0);
    repeat (3) drive_phase(6, 0);

    // Clear colliding with a glitch-generating fall
    set_mins(3, 0);
    if (cur_level) drive_phase(10, 0);
    drive_phase(2, 0);
    drive_phase(10, 2);
    repeat (4) drive_phase(6, 0);

    // Clear in the middle of a high phase
    if (cur_level) drive_phase(6, 0);
    drive_phase(12, 1);
    repeat (4) drive_phase(6, 0);

    // Reset in the middle of a high phase
    if (cur_level) drive_phase(6, 0);
    drive_phase(20, 3);
    repeat (5) drive_phase(5, 0);

    repeat (2) random_segment(40);

    repeat (8) @(negedge clk);
    check("final_meas_queue_empty", meas_q.size(), 0);
    check("final_glitch_queue_empty", glitch_q.size(), 0);
    check("final_glitch_cnt", int'(glitch_cnt), gcnt_m);
    check("final_glitch_sticky", int'(glitch_sticky), int'(sticky_m));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
